shift_seq_ctrl: RTL and testbench

- Multi-cycle shift unit for the MIPS execute stage: sequences an iterative shift datapath over several clocks instead of a full 32-bit barrel shifter.
- Covers SLL/SRL/SRA (fixed and variable amounts) and LUI (shift-left-16).
- Provides a start/done handshake and a stall output for the pipeline hazard logic.
- Each cycle shifts by at most MAX_STEP positions.

---
 rtl/shift_seq_ctrl_if.sv | 40 ++++
 rtl/shift_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_shift_seq_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/shift_seq_ctrl_if.sv
// Handshake and data bundle for the iterative shift unit.
// Master is the requesting execute stage; slave is shift_seq_ctrl.
interface shift_seq_ctrl_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [2:0]         op;
  logic [WIDTH-1:0]   operand;
  logic [SHAMT_W-1:0] shamt;
  logic               flush;
  logic [WIDTH-1:0]   result;
  logic               busy;
  logic               done;
  logic               stall;

  modport master (
    output start,
    output op,
    output operand,
    output shamt,
    output flush,
    input  result,
    input  busy,
    input  done,
    input  stall
  );

  modport slave (
    input  start,
    input  op,
    input  operand,
    input  shamt,
    input  flush,
    output result,
    output busy,
    output done,
    output stall
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle SLL/SRL/SRA/LUI shift sequencer, MAX_STEP bits per clock.
// Optional rotate-right (op 101) enabled by defining SHIFT_ROTATE_EN.
module shift_seq_ctrl #(
  parameter int WIDTH    = 32,
  parameter int SHAMT_W  = 5,
  parameter int MAX_STEP = 4
) (
  input  logic             clk,
  input  logic             reset,
  shift_seq_ctrl_if.slave  bus
);

  localparam int RW = SHAMT_W + 1;

  localparam logic [2:0] OP_SLL  = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SRA  = 3'b011;
  localparam logic [2:0] OP_LUI  = 3'b100;
`ifdef SHIFT_ROTATE_EN
  localparam logic [2:0] OP_ROTR = 3'b101;
`endif

  localparam logic [RW-1:0] MAX_S = RW'(MAX_STEP);
  localparam logic [RW-1:0] LUI_S = RW'(16);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] shifted;
  logic [2:0]       op_q;
  logic [RW-1:0]    rem;
  logic [RW-1:0]    step;
  logic [RW-1:0]    rem_init;
  logic             load;
  logic             adv;
  logic             fin;
  logic             is_lui;
  logic             is_sh;

  // Amount applied this RUN cycle: whatever is left, capped at MAX_STEP.
  always_comb begin
    step = (rem > MAX_S) ? MAX_S : rem;
  end

  // Classify the incoming op into the initial remaining count.
  always_comb begin
    is_lui = (bus.op == OP_LUI);
    is_sh  = (bus.op == OP_SLL) ||
             (bus.op == OP_SRL) ||
`ifdef SHIFT_ROTATE_EN
             (bus.op == OP_ROTR) ||
`endif
             (bus.op == OP_SRA);
    rem_init = '0;
    unique case (1'b1)
      is_lui:  rem_init = LUI_S;
      is_sh:   rem_init = {1'b0, bus.shamt};
      default: rem_init = '0;
    endcase
  end

  // One iteration of the shift datapath on the accumulator.
  always_comb begin
    shifted = acc;
    case (op_q)
      OP_SLL,
      OP_LUI:  shifted = acc << step;
      OP_SRL:  shifted = acc >> step;
      OP_SRA:  shifted = $unsigned($signed(acc) >>> step);
`ifdef SHIFT_ROTATE_EN
      OP_ROTR: begin
        logic [2*WIDTH-1:0] dbl;
        dbl     = {acc, acc} >> step;
        shifted = dbl[WIDTH-1:0];
      end
`endif
      default: shifted = acc;
    endcase
  end

  // Next-state and datapath control; flush outranks start and completion.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    adv     = 1'b0;
    fin     = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.flush && bus.start) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_n = IDLE;
        end else begin
          adv = 1'b1;
          if (rem == step) begin
            fin     = 1'b1;
            state_n = DONE;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register plus registered busy/done decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state    <= state_n;
      bus.busy <= (state_n == RUN);
      bus.done <= (state_n == DONE);
    end
  end

  // Accumulator, op latch, remaining count and result register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc        <= '0;
      op_q       <= '0;
      rem        <= '0;
      bus.result <= '0;
    end else begin
      if (load) begin
        acc  <= bus.operand;
        op_q <= bus.op;
        rem  <= rem_init;
      end else if (adv) begin
        acc <= shifted;
        rem <= rem - step;
      end
      if (fin) begin
        bus.result <= shifted;
      end
    end
  end

  // Hold the pipeline from request through the final RUN cycle.
  always_comb begin
    bus.stall = ((state == IDLE) && bus.start) || (state == RUN);
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with MAX_STEP=4.
// Rotate expectations follow SHIFT_ROTATE_EN.
module tb_shift_seq_ctrl;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   cyc;

  shift_seq_ctrl_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  shift_seq_ctrl #(
    .WIDTH(32),
    .SHAMT_W(5),
    .MAX_STEP(4)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] opd, input logic [4:0] sh,
                        input bit toggle, input int exp_n,
                        input logic [31:0] exp_res);
    int n;
    bus.start   = 1'b1;
    bus.op      = op;
    bus.operand = opd;
    bus.shamt   = sh;
    #1;
    chk({tag, ".stall_req"}, 32'(bus.stall), 32'd1);
    tick();
    bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 64) begin
      n++;
      if (toggle) bus.shamt = ~bus.shamt;
      chk({tag, ".stall_run"}, 32'(bus.stall), 32'd1);
      tick();
    end
    chk({tag, ".ncyc"}, 32'(n), 32'(exp_n));
    chk({tag, ".done"}, 32'(bus.done), 32'd1);
    chk({tag, ".busy0"}, 32'(bus.busy), 32'd0);
    chk({tag, ".stall0"}, 32'(bus.stall), 32'd0);
    chk({tag, ".result"}, bus.result, exp_res);
    tick();
    chk({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    bus.start   = 1'b0;
    bus.op      = 3'b000;
    bus.operand = '0;
    bus.shamt   = '0;
    bus.flush   = 1'b0;
    rst_n       = 1'b1;
    #2 rst_n    = 1'b0;
    tick();
    tick();
    chk("rst.result", bus.result, 32'h0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk("rst.stall", 32'(bus.stall), 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("sll5", 3'b000, 32'h0000_0001, 5'd5, 0, 2, 32'h0000_0020);
    run_op("sra31", 3'b011, 32'h8000_0000, 5'd31, 0, 8, 32'hFFFF_FFFF);
    run_op("srl31", 3'b001, 32'h8000_0000, 5'd31, 0, 8, 32'h0000_0001);
    run_op("lui", 3'b100, 32'h1234_ABCD, 5'd3, 1, 4, 32'hABCD_0000);
    run_op("pass", 3'b010, 32'h0000_0055, 5'd7, 0, 1, 32'h0000_0055);

    // start held high through DONE
    bus.start   = 1'b1;
    bus.op      = 3'b001;
    bus.operand = 32'hDEAD_BEEF;
    bus.shamt   = 5'd0;
    tick();
    chk("hold.busy_run", 32'(bus.busy), 32'd1);
    bus.op      = 3'b000;
    bus.operand = 32'h0000_000F;
    bus.shamt   = 5'd4;
    tick();
    chk("hold.done", 32'(bus.done), 32'd1);
    chk("hold.result", bus.result, 32'hDEAD_BEEF);
    tick();
    chk("hold.idle_busy", 32'(bus.busy), 32'd0);
    chk("hold.idle_stall", 32'(bus.stall), 32'd1);
    tick();
    bus.start = 1'b0;
    chk("hold.accept", 32'(bus.busy), 32'd1);
    tick();
    chk("hold.done2", 32'(bus.done), 32'd1);
    chk("hold.result2", bus.result, 32'h0000_00F0);
    tick();

    run_op("sll5b", 3'b000, 32'h0000_0001, 5'd5, 0, 2, 32'h0000_0020);

    // flush during first RUN cycle of SLL by 12
    bus.start   = 1'b1;
    bus.op      = 3'b000;
    bus.operand = 32'h0000_0001;
    bus.shamt   = 5'd12;
    tick();
    bus.start = 1'b0;
    chk("flush.run", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush.busy", 32'(bus.busy), 32'd0);
    chk("flush.done", 32'(bus.done), 32'd0);
    chk("flush.result", bus.result, 32'h0000_0020);
    tick();
    chk("flush.done_late", 32'(bus.done), 32'd0);

    // flush on the completing RUN cycle
    bus.start = 1'b1;
    bus.shamt = 5'd3;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flushfin.done", 32'(bus.done), 32'd0);
    chk("flushfin.result", bus.result, 32'h0000_0020);
    tick();

    // flush outranks start in IDLE
    bus.start = 1'b1;
    bus.flush = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("flushidle.busy", 32'(bus.busy), 32'd0);
    tick();

    // asynchronous reset mid-RUN
    bus.start = 1'b1;
    bus.shamt = 5'd12;
    tick();
    bus.start = 1'b0;
    tick();
    chk("arst.pre_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.busy", 32'(bus.busy), 32'd0);
    chk("arst.done", 32'(bus.done), 32'd0);
    chk("arst.result", bus.result, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef SHIFT_ROTATE_EN
    run_op("rotr", 3'b101, 32'h0000_0001, 5'd1, 0, 1, 32'h8000_0000);
`else
    run_op("rotr", 3'b101, 32'h0000_0001, 5'd1, 0, 1, 32'h0000_0001);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
